conv_window_fifo: RTL
=====================

Name: conv_window_fifo

Overview:
- Parametrised line-buffer FIFO for the convolution engine. Accepts a raster-order pixel stream and presents a full KxK window in one registered output bus.
- Generalises the fixed 3x3 window to kernel size K. Gates window reads on data sufficiency.
- Handles horizontal stride and row-end wrap itself, so the downstream MAC array never sees a window that straddles two rows.

Parameters:
- WIDTH, 8, pixel width in bits.
- ADDR_BIT, 6, storage address bits; DEPTH = 2**ADDR_BIT entries.
- K, 3, kernel size; legal range 2..5.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wen  in  1  write request
- in  in  WIDTH  pixel to write
- full  out  1  cnt == DEPTH
- ren  in  1  window accept request
- win_ready  out  1  a complete window is present at the read pointer and cfg_err is 0
- win_valid  out  1  win_out holds a valid window
- win_out  out  K*K*WIDTH  window; element (r,c) at bits [(r*K+c)*WIDTH +: WIDTH], r=0 is the oldest row, c=0 is the leftmost column
- empty  out  1  cnt == 0
- cnt  out  ADDR_BIT+1  occupancy
- col  out  ADDR_BIT  left column of the current window
- row_len  in  ADDR_BIT  image row length
- stride  in  3  horizontal stride; value 0 is treated as 1
- cfg_err  out  1  illegal configuration
- err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, rst high):
  - Pointers, cnt, col, win_out, win_valid and err go to 0.
  - Storage contents need not be cleared.
- Configuration:
  - row_len and stride must be held static while cnt != 0.
  - cfg_err = (row_len < K) | ((K-1)*row_len + K > DEPTH). Computed at ADDR_BIT+4 bits so it cannot overflow.
- Write:
  - When wen & !full: store in at wr_ptr, wr_ptr++ (ADDR_BIT+1 bits, wraps).
  - When wen & full: data is dropped and err is set.
- Readiness: win_ready = !cfg_err & (cnt >= (K-1)*row_len + K).
- Window address: element (r,c) is read at rd_ptr + r*row_len + c, modulo DEPTH.
- Accept (ren & win_ready):
  - win_out is loaded with the window at the current rd_ptr; win_valid = 1 on the next cycle. Read latency is 1 cycle.
  - Pop amount p:
    - If col + s + K <= row_len (s = effective stride): p = s and col += s.
    - Otherwise: p = row_len - col and col = 0 (row wrap; the next window starts on the next image row, vertical stride 1).
  - rd_ptr += p.
- ren & !win_ready: no state change except err is set. win_out and win_valid hold.
- win_valid stays 1 until reset. win_out changes only on accept.
- Occupancy update: cnt_next = cnt + (write accepted ? 1 : 0) - (accept ? p : 0).
  - A simultaneous write and accept apply both terms in the same cycle.
  - p <= cnt is guaranteed whenever win_ready is 1 (K >= 2).
- A write in the same cycle as an accept does not affect the window captured in that cycle. win_ready is evaluated on the pre-update cnt.
- Pointer wrap: rd_ptr and wr_ptr carry an extra MSB. full/empty are derived from cnt, which is the single source of truth.
- Reset mid-operation: all partial windows are discarded and the next window needs a full refill.
- Control FSM, two states:
  - FILL: win_ready = 0. Move to STREAM when the readiness condition is met.
  - STREAM: accepts allowed. Return to FILL when cnt drops below the threshold after a pop.
  - Reset enters FILL.

Decomposition:
- Shared package conv_pkg holds:
  - MAX_K = 5
  - the window index function idx(r,c) = (r*K+c)*WIDTH
  - the threshold function need(row_len) = (K-1)*row_len + K
- One natural sub-module: conv_window_addr_gen. It is combinational and produces K*K read addresses from rd_ptr and row_len. It is instantiated once.
- The FSM, counters and storage stay in the top module.

Test Plan:
- K=3, row_len=4, stride=1; write 0..11.
  - After the 11th write: win_ready=1, cnt=11.
  - First ren: rows {0,1,2},{4,5,6},{8,9,10}; then cnt=11, col=1.
- Continue the above with a second ren:
  - Window rows {1,2,3},{5,6,7},{9,10,11}.
  - Row wrap: p=3, col=0, cnt=8, win_ready=0 until 3 more writes arrive.
- K=3, row_len=6, stride=2; write 0..20:
  - Windows start at columns 0, 2, then wrap.
  - The third accept starts at pixel 6 with col=0.
- Simultaneous wen and ren with cnt=11, row_len=4, stride=1 → cnt stays 11; the captured window is unaffected by the new pixel.
- Fill until full (cnt=64) then wen → data dropped, err=1. ren with win_ready=0 on an empty FIFO → err=1, win_valid unchanged.
- row_len=2 with K=3 → cfg_err=1 and win_ready=0. Assert rst mid-stream → cnt=0, win_valid=0, err=0 without waiting for a clock edge.

Source files
------------

// File: rtl/conv_window_fifo_pkg.sv
// Shared types and helpers for the KxK convolution window line buffer.
// Window bit offsets and the fill threshold live here so every user agrees on them.
package conv_pkg;

    localparam int MAX_K = 5;

    typedef enum logic {
        FILL,
        STREAM
    } state_t;

    // Bit offset of window element (r,c); r=0 is the oldest row, c=0 the leftmost column.
    function automatic int idx(input int r, input int c, input int k, input int width);
        return (r * k + c) * width;
    endfunction

    // Pixels that must be buffered before the first window of a row is complete.
    function automatic int need(input int row_len, input int k);
        return (k - 1) * row_len + k;
    endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// Combinational generator of the K*K storage addresses of the window anchored at base.
// Truncation to ADDR_BIT bits gives the modulo-DEPTH wrap of the circular buffer.
module conv_window_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_BIT = 6,
    parameter int K        = 3
) (
    input  logic [ADDR_BIT-1:0]     base,
    input  logic [ADDR_BIT-1:0]     row_len,
    output logic [K*K*ADDR_BIT-1:0] addr
);

    // NOTE: combinational outputs get a default before any loop or branch so no latch is inferred.
    always_comb begin
        addr = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                addr[idx(r, c, K, ADDR_BIT) +: ADDR_BIT] =
                    base + ADDR_BIT'(r) * row_len + ADDR_BIT'(c);
            end
        end
    end

endmodule

// File: rtl/conv_window_fifo.sv
// Raster-order line-buffer FIFO presenting a registered KxK window per accept.
// Handles horizontal stride and row-end wrap so no window straddles two image rows.
module conv_window_fifo
    import conv_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ADDR_BIT = 6,
    parameter int K        = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic [WIDTH-1:0]       in,
    output logic                   full,
    input  logic                   ren,
    output logic                   win_ready,
    output logic                   win_valid,
    output logic [K*K*WIDTH-1:0]   win_out,
    output logic                   empty,
    output logic [ADDR_BIT:0]      cnt,
    output logic [ADDR_BIT-1:0]    col,
    input  logic [ADDR_BIT-1:0]    row_len,
    input  logic [2:0]             stride,
    output logic                   cfg_err,
    output logic                   err
);

    localparam int DEPTH = 1 << ADDR_BIT;
    localparam int CW    = ADDR_BIT + 4;

    logic [WIDTH-1:0]         mem [DEPTH];
    logic [ADDR_BIT:0]        wr_ptr, rd_ptr, cnt_next;
    logic [ADDR_BIT-1:0]      col_next;
    logic [CW-1:0]            thr, s_eff, pop;
    logic [K*K*ADDR_BIT-1:0]  rd_addr;
    logic                     ready_cond, wr_acc, accept;
    state_t                   state, state_next;

    conv_window_addr_gen #(.ADDR_BIT(ADDR_BIT), .K(K)) u_addr_gen (
        .base    (rd_ptr[ADDR_BIT-1:0]),
        .row_len (row_len),
        .addr    (rd_addr)
    );

    // Threshold is computed wide enough that (K-1)*row_len+K never overflows.
    always_comb begin
        thr        = CW'(need(int'(row_len), K));
        cfg_err    = (CW'(row_len) < CW'(K)) || (thr > CW'(DEPTH));
        ready_cond = !cfg_err && (CW'(cnt) >= thr);
    end

    assign full      = (cnt == (ADDR_BIT+1)'(DEPTH));
    assign empty     = (cnt == '0);
    assign win_ready = (state == STREAM) && ready_cond;
    assign wr_acc    = wen && !full;
    assign accept    = ren && win_ready;

    // Pop a full stride if the next window still fits in the row, else skip to the next row.
    always_comb begin
        s_eff    = (stride == 3'd0) ? CW'(1) : CW'(stride);
        pop      = s_eff;
        col_next = col + ADDR_BIT'(s_eff);
        if (CW'(col) + s_eff + CW'(K) > CW'(row_len)) begin
            pop      = CW'(row_len) - CW'(col);
            col_next = '0;
        end
        cnt_next = cnt + (ADDR_BIT+1)'(wr_acc)
                 - (accept ? (ADDR_BIT+1)'(pop) : (ADDR_BIT+1)'(0));
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (!cfg_err && CW'(cnt_next) >= thr) state_next = STREAM;
            STREAM:  if (CW'(cnt_next) < thr)              state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            col       <= '0;
            win_out   <= '0;
            win_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (accept) begin
                rd_ptr    <= rd_ptr + (ADDR_BIT+1)'(pop);
                col       <= col_next;
                win_valid <= 1'b1;
                for (int i = 0; i < K * K; i++) begin
                    win_out[i*WIDTH +: WIDTH] <= mem[rd_addr[i*ADDR_BIT +: ADDR_BIT]];
                end
            end
            if ((wen && full) || (ren && !win_ready)) err <= 1'b1;
        end
    end

    // NOTE: the pixel store has no reset; cnt and the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[ADDR_BIT-1:0]] <= in;
    end

endmodule
